// File: rtl/fft_mem_arbiter.sv
// fft_mem_arbiter: shares one port of the spectrum analyser's sample BRAM between
// N_REQ requesters (FFT datapath, grapher readout, loader/debug). Round-robin or
// fixed-priority grant, locked bursts with a starvation bound, 1-cycle read valid.
module fft_mem_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 64
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_lock,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [ADDR_W-1:0]         o_bram_addr,
    output logic [DATA_W-1:0]         o_bram_wdata,
    output logic                      o_bram_we,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic                      o_busy
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CW     = IDX_W + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [N_REQ-1:0]   others_req;
    logic [N_REQ-1:0]   arb_req;
    logic               owner_keep;
    logic               starve;
    logic               win_vld;
    logic               win_lock;
    logic [IDX_W-1:0]   win_idx;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;

    // Lock owner bookkeeping: does the owner keep the port, or has a waiter hit the hold bound
    always_comb begin
        others_req = i_req;
        owner_keep = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state == LOCKED && owner == IDX_W'(i)) begin
                others_req[i] = 1'b0;
                owner_keep    = i_req[i] & i_lock[i];
            end
        end
        starve  = owner_keep && (hold_cnt >= HOLD_W'(MAX_HOLD)) && (|others_req);
        // A starved owner sits out this cycle; everyone else arbitrates normally
        arb_req = starve ? others_req : i_req;
    end

    // First requesting index scanning upward from the rr pointer (or from 0 in fixed mode)
    always_comb begin
        logic [CW-1:0] cand;
        cand     = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (FIXED_PRIO != 0) ? CW'(i) : CW'(rr_ptr) + CW'(i);
            if (cand >= CW'(N_REQ))
                cand = cand - CW'(N_REQ);
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_vld && cand == CW'(j) && arb_req[j]) begin
                    win_vld  = 1'b1;
                    win_idx  = IDX_W'(j);
                    win_lock = i_lock[j];
                end
            end
        end
    end

    // Final grant: a kept lock overrides arbitration
    always_comb begin
        gnt_vld = win_vld;
        gnt_idx = win_idx;
        if (owner_keep && !starve) begin
            gnt_vld = 1'b1;
            gnt_idx = owner;
        end
    end

    // BRAM port mux; grant and write enable are gated by reset so they drop without a clock
    always_comb begin
        o_gnt        = '0;
        o_bram_we    = 1'b0;
        o_bram_addr  = addr_q;
        o_bram_wdata = wdata_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_rst_n && gnt_vld && gnt_idx == IDX_W'(i)) begin
                o_gnt[i]     = 1'b1;
                o_bram_we    = i_we[i];
                o_bram_addr  = i_addr[i*ADDR_W +: ADDR_W];
                o_bram_wdata = i_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_busy = (state == LOCKED);

    // Lock FSM, rr pointer, hold counter, held BRAM address/data and read-valid pipeline
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            o_rvalid <= '0;
        end else begin
            o_rvalid <= o_gnt & ~i_we;
            if (gnt_vld) begin
                rr_ptr  <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                addr_q  <= o_bram_addr;
                wdata_q <= o_bram_wdata;
            end
            if (owner_keep && !starve) begin
                if (|others_req)
                    hold_cnt <= hold_cnt + 1'b1;
            end else if (win_vld && win_lock) begin
                state    <= LOCKED;
                owner    <= win_idx;
                hold_cnt <= HOLD_W'(1);
            end else begin
                state    <= IDLE;
                hold_cnt <= '0;
            end
        end
    end
endmodule
